// File: rtl/uart_cmd_ctrl_pkg.sv
// rtl/uart_cmd_ctrl_pkg.sv - shared states, error codes and checksum helper for the UART command controller
package uart_cmd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_LEN    = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_COMMIT = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_LEN     = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_OVERRUN = 2'd3
   } err_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
      return sum + b;
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_cmd_buf.sv
// rtl/uart_cmd_ctrl_cmd_buf.sv - payload buffer, synchronous write, asynchronous read
module cmd_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - framed write-command parser that replays a checksummed payload as register writes
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 25000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   output logic       frame_done,
   output logic       err_valid,
   output logic [1:0] err_code
);

   localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t             state, state_nxt;
   logic [7:0]         sum;
   logic [7:0]         base;
   logic [8:0]         len;
   logic [8:0]         idx;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               waiting;
   logic               tmo_hit;
   logic               last_idx;
   logic               buf_we;
   logic               err_set;
   err_t               err_code_nxt;
   logic               done_set;
   logic [7:0]         buf_rdata;

   cmd_buf #(.DEPTH(MAX_LEN), .AW(PTR_W)) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (idx[PTR_W-1:0]),
      .wdata (rx_data),
      .raddr (idx[PTR_W-1:0]),
      .rdata (buf_rdata)
   );

   assign waiting  = (state == ST_ADDR) || (state == ST_LEN) ||
                     (state == ST_DATA) || (state == ST_CSUM);
   assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign last_idx = (idx == len - 9'd1);
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      buf_we       = 1'b0;
      err_set      = 1'b0;
      err_code_nxt = ERR_LEN;
      done_set     = 1'b0;
      wr_valid     = 1'b0;
      wr_addr      = 8'h00;
      wr_data      = 8'h00;
      case (state)
         ST_IDLE: begin
            if (rx_ready && rx_data == SYNC_BYTE) state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            if (rx_ready) state_nxt = ST_LEN;
         end
         ST_LEN: begin
            if (rx_ready) begin
               if (rx_data == 8'h00 || {1'b0, rx_data} > 9'(MAX_LEN)) begin
                  state_nxt    = ST_IDLE;
                  err_set      = 1'b1;
                  err_code_nxt = ERR_LEN;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (rx_ready) begin
               buf_we = 1'b1;
               if (last_idx) state_nxt = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (rx_ready) begin
               if (rx_data == sum) begin
                  state_nxt = ST_COMMIT;
               end else begin
                  state_nxt    = ST_IDLE;
                  err_set      = 1'b1;
                  err_code_nxt = ERR_CSUM;
               end
            end
         end
         ST_COMMIT: begin
            wr_valid = 1'b1;
            wr_addr  = base + idx[7:0];
            wr_data  = buf_rdata;
            if (wr_ready && last_idx) begin
               state_nxt = ST_IDLE;
               done_set  = 1'b1;
            end
            // Bytes arriving mid-commit are discarded; the burst carries on.
            if (rx_ready) begin
               err_set      = 1'b1;
               err_code_nxt = ERR_OVERRUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (waiting && !rx_ready && tmo_hit) begin
         state_nxt    = ST_IDLE;
         err_set      = 1'b1;
         err_code_nxt = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum        <= 8'h00;
         base       <= 8'h00;
         len        <= 9'd0;
         idx        <= 9'd0;
         tmo_cnt    <= '0;
         frame_done <= 1'b0;
         err_valid  <= 1'b0;
         err_code   <= 2'd0;
      end else begin
         frame_done <= done_set;
         err_valid  <= err_set;
         if (err_set) err_code <= err_code_nxt;

         if (rx_ready || !waiting) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end

         case (state)
            ST_IDLE:   sum <= 8'h00;
            ST_ADDR:   if (rx_ready) begin
                          base <= rx_data;
                          sum  <= csum_add(sum, rx_data);
                       end
            ST_LEN:    if (rx_ready) begin
                          len <= {1'b0, rx_data};
                          sum <= csum_add(sum, rx_data);
                          idx <= 9'd0;
                       end
            ST_DATA:   if (rx_ready) begin
                          idx <= idx + 9'd1;
                          sum <= csum_add(sum, rx_data);
                       end
            ST_CSUM:   if (rx_ready) idx <= 9'd0;
            ST_COMMIT: if (wr_ready) idx <= idx + 9'd1;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - randomized self-checking bench for uart_cmd_ctrl against a frame-level model
module tb_uart_cmd_ctrl;

   localparam int MAXL = 16;
   localparam int TMO  = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       wr_ready = 1'b0;
   logic       wr_valid, busy, frame_done, err_valid;
   logic [7:0] wr_addr, wr_data;
   logic [1:0] err_code;

   uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .frame_done (frame_done),
      .err_valid  (err_valid),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // wr_ready pattern: 0 always ready, 1 random, 2 held low
   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       wr_ready = 1'b1;
         1:       wr_ready = ($urandom_range(0, 3) != 0);
         default: wr_ready = 1'b0;
      endcase
   end

   int          cyc = 0;
   int          last_rx_cyc = 0;
   logic [15:0] obs_w[$];
   int          obs_wcyc[$];
   logic [1:0]  obs_err[$];
   int          obs_ecyc[$];
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_addr = 8'h00, prev_data = 8'h00;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (rx_ready) last_rx_cyc = cyc;
         if (prev_stall) begin
            check_eq("hold_valid", wr_valid, 1);
            check_eq("hold_addr", wr_addr, prev_addr);
            check_eq("hold_data", wr_data, prev_data);
         end
         if (wr_valid && wr_ready) begin
            obs_w.push_back({wr_addr, wr_data});
            obs_wcyc.push_back(cyc);
         end
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err_valid) begin
            obs_err.push_back(err_code);
            obs_ecyc.push_back(cyc);
         end
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
      end
   end

   logic [7:0]  pay [256];
   logic [15:0] exp_w[$];
   logic [1:0]  exp_err[$];
   int          exp_done;

   task automatic clear_obs();
      obs_w.delete();
      obs_wcyc.delete();
      obs_err.delete();
      obs_ecyc.delete();
      done_cnt = 0;
      exp_w.delete();
      exp_err.delete();
      exp_done = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_ready = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_ready = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   // Frame-level model: a frame either commits its whole payload or reports one error.
   task automatic send_frame(input logic [7:0] addr, input int len, input logic [7:0] bad, input int njunk);
      int         s;
      logic [7:0] b;
      clear_obs();
      for (int j = 0; j < njunk; j++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h00;
         send_byte(b, $urandom_range(0, 3));
      end
      send_byte(8'hA5, $urandom_range(0, 3));
      send_byte(addr, $urandom_range(0, 3));
      send_byte(8'(len), $urandom_range(0, 3));
      if (len == 0 || len > MAXL) begin
         exp_err.push_back(2'd0);
         return;
      end
      s = addr + len;
      for (int i = 0; i < len; i++) begin
         s += pay[i];
         send_byte(pay[i], $urandom_range(0, 3));
      end
      send_byte(8'(s % 256) ^ bad, 0);
      if (bad != 8'h00) begin
         exp_err.push_back(2'd1);
      end else begin
         for (int i = 0; i < len; i++) exp_w.push_back({8'((addr + i) % 256), pay[i]});
         exp_done = 1;
      end
   endtask

   task automatic finish_frame();
      int n;
      repeat (2) @(negedge clk);
      n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("settle_idle", busy, 0);
      repeat (2) @(negedge clk);
      check_eq("n_writes", obs_w.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) check_eq("write", obs_w[i], exp_w[i]);
      check_eq("n_done", done_cnt, exp_done);
      check_eq("n_err", obs_err.size(), exp_err.size());
      for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) check_eq("err_code", obs_err[i], exp_err[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_wr_valid"}, wr_valid, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_frame_done"}, frame_done, 0);
      check_eq({tag, "_err_valid"}, err_valid, 0);
      check_eq({tag, "_wr_addr"}, wr_addr, 0);
      check_eq({tag, "_wr_data"}, wr_data, 0);
      check_eq({tag, "_err_code"}, err_code, 0);
   endtask

   initial begin
      int t0, n, r, len;
      logic [7:0] bad;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // good two-byte frame with wr_ready high: back-to-back writes
      rdy_mode = 0;
      pay[0] = 8'h11; pay[1] = 8'h22;
      send_frame(8'h10, 2, 8'h00, 0);
      finish_frame();
      if (obs_wcyc.size() == 2) begin
         check_eq("first_wr_latency", obs_wcyc[0] - last_rx_cyc, 1);
         check_eq("wr_back_to_back", obs_wcyc[1] - obs_wcyc[0], 1);
         check_eq("done_after_last", done_cyc - obs_wcyc[1], 1);
      end

      // checksum error
      send_frame(8'h10, 2, 8'h03, 0);
      finish_frame();
      if (obs_ecyc.size() == 1) check_eq("csum_err_latency", obs_ecyc[0] - last_rx_cyc, 1);

      // length boundaries
      send_frame(8'h10, 0, 8'h00, 0);
      finish_frame();
      send_frame(8'h10, MAXL + 1, 8'h00, 0);
      finish_frame();
      pay[0] = 8'h5C; pay[15] = 8'hC5;
      send_frame(8'h40, MAXL, 8'h00, 0);
      finish_frame();

      // address wrap
      pay[0] = 8'h01; pay[1] = 8'h02;
      send_frame(8'hFF, 2, 8'h00, 0);
      finish_frame();

      // inter-byte timeout, then recovery
      clear_obs();
      send_byte(8'hA5, 0);
      send_byte(8'h10, 0);
      t0 = last_rx_cyc;
      n = 0;
      while (obs_err.size() == 0 && n < TMO + 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("tmo_n_err", obs_err.size(), 1);
      if (obs_err.size() > 0) begin
         check_eq("tmo_code", obs_err[0], 2);
         check_eq("tmo_window", (obs_ecyc[0] - t0 >= TMO) && (obs_ecyc[0] - t0 <= TMO + 2), 1);
      end
      @(negedge clk);
      check_eq("tmo_idle", busy, 0);
      pay[0] = 8'h77;
      send_frame(8'h20, 1, 8'h00, 0);
      finish_frame();

      // stalled commit with overrun byte
      rdy_mode = 2;
      pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
      send_frame(8'h30, 3, 8'h00, 0);
      @(negedge clk);
      check_eq("stall_busy", busy, 1);
      check_eq("stall_valid", wr_valid, 1);
      send_byte(8'h5A, 0);
      exp_err.push_back(2'd3);
      repeat (3) @(posedge clk);
      rdy_mode = 0;
      finish_frame();

      // reset mid-DATA abandons the frame
      clear_obs();
      send_byte(8'hA5, 0);
      send_byte(8'h50, 0);
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      repeat (10) @(negedge clk);
      check_eq("midrst_writes", obs_w.size(), 0);
      check_eq("midrst_done", done_cnt, 0);
      check_eq("midrst_err", obs_err.size(), 0);

      // randomized frames
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 19);
         if (r == 0)      len = 0;
         else if (r == 1) len = $urandom_range(MAXL + 1, 40);
         else             len = $urandom_range(1, MAXL);
         for (int i = 0; i < MAXL; i++) pay[i] = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         rdy_mode = $urandom_range(0, 1);
         send_frame(8'($urandom), len, bad, $urandom_range(0, 2));
         finish_frame();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
